// File: rtl/hsv_core_dmem_responder_if.sv
// AXI-Lite bundle between the core memory unit (master) and the dmem responder (slave).
interface axil_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport m (
    output araddr, arvalid, input arready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input rdata, rresp, rvalid, output rready,
    input bresp, bvalid, output bready
  );

  modport s (
    input araddr, arvalid, output arready,
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output rdata, rresp, rvalid, input rready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/hsv_core_dmem_responder.sv
// AXI-Lite data-memory responder: single-port byte-strobed RAM shared by independent
// read and write FSMs through a one-access-per-cycle alternating-priority arbiter.
module hsv_core_dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned SIZE_WORDS  = 4096,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic clk_core,
  input  logic rst_core_n,
  axil_if.s    dmem
);
  localparam int unsigned IDX_W     = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
  localparam logic [32:0] BASE_EXT  = {1'b0, ADDR_BASE};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'(SIZE_WORDS) << 2);
  localparam logic [3:0]  WAIT_N    = 4'(WAIT_CYCLES);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_COLLECT, W_ACCESS, W_WAIT, W_RESP} wr_state_e;

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= BASE_EXT) && ({1'b0, a} < LIMIT_EXT);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  logic [31:0] mem [SIZE_WORDS];
  logic [31:0] ram_rd_q;

  logic        alive_q;
  rd_state_e   rstate_q, rstate_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  wr_state_e   wstate_q, wstate_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;

  logic        prio_w_q, prio_w_d;
  logic        rd_req, wr_req, gnt_r, gnt_w;
  logic        ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic        rd_ok, wr_ok;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  assign dmem.arready = alive_q & ((rstate_q == R_IDLE) | ((rstate_q == R_RESP) & dmem.rready));
  assign dmem.awready = alive_q & (((wstate_q == W_COLLECT) & ~aw_held_q) |
                                   ((wstate_q == W_RESP) & dmem.bready));
  assign dmem.wready  = alive_q & (((wstate_q == W_COLLECT) & ~w_held_q) |
                                   ((wstate_q == W_RESP) & dmem.bready));
  assign dmem.rvalid  = (rstate_q == R_RESP);
  assign dmem.rdata   = rdata_q;
  assign dmem.rresp   = rresp_q;
  assign dmem.bvalid  = (wstate_q == W_RESP);
  assign dmem.bresp   = bresp_q;

  assign ar_hs = dmem.arvalid & dmem.arready;
  assign aw_hs = dmem.awvalid & dmem.awready;
  assign w_hs  = dmem.wvalid & dmem.wready;
  assign r_hs  = dmem.rvalid & dmem.rready;
  assign b_hs  = dmem.bvalid & dmem.bready;

  assign rd_ok  = in_range(araddr_q);
  assign wr_ok  = in_range(awaddr_q);
  assign rd_idx = word_idx(araddr_q);
  assign wr_idx = word_idx(awaddr_q);

  // The path holding priority wins a same-cycle collision; the loser gets the next cycle.
  always_comb begin
    rd_req   = (rstate_q == R_ACCESS);
    wr_req   = (wstate_q == W_ACCESS);
    gnt_w    = wr_req & (~rd_req | prio_w_q);
    gnt_r    = rd_req & (~wr_req | ~prio_w_q);
    prio_w_d = (rd_req & wr_req) ? ~prio_w_q : prio_w_q;
  end

  // R_WAIT always lasts at least one cycle: it is the RAM output-register stage.
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    araddr_d = araddr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          araddr_d = dmem.araddr;
          rstate_d = R_ACCESS;
        end
      end
      R_ACCESS: begin
        if (gnt_r) begin
          rcnt_d   = WAIT_N;
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          rdata_d  = rd_ok ? ram_rd_q : '0;
          rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
          rstate_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (r_hs) begin
          rstate_d = ar_hs ? R_ACCESS : R_IDLE;
          if (ar_hs) araddr_d = dmem.araddr;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d  = wstate_q;
    wcnt_d    = wcnt_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    if (b_hs) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (aw_hs) begin
      awaddr_d  = dmem.awaddr;
      aw_held_d = 1'b1;
    end
    if (w_hs) begin
      wdata_d  = dmem.wdata;
      wstrb_d  = dmem.wstrb;
      w_held_d = 1'b1;
    end
    unique case (wstate_q)
      W_COLLECT: begin
        if (aw_held_d && w_held_d) wstate_d = W_ACCESS;
      end
      W_ACCESS: begin
        if (gnt_w) begin
          bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
          if (WAIT_N == '0) begin
            wstate_d = W_RESP;
          end else begin
            wcnt_d   = WAIT_N - 4'd1;
            wstate_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) wstate_d = W_RESP;
        else              wcnt_d   = wcnt_q - 4'd1;
      end
      W_RESP: begin
        if (b_hs) wstate_d = (aw_held_d && w_held_d) ? W_ACCESS : W_COLLECT;
      end
      default: wstate_d = W_COLLECT;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      alive_q   <= 1'b0;
      prio_w_q  <= 1'b1;
      rstate_q  <= R_IDLE;
      rcnt_q    <= '0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      wstate_q  <= W_COLLECT;
      wcnt_q    <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      alive_q   <= 1'b1;
      prio_w_q  <= prio_w_d;
      rstate_q  <= rstate_d;
      rcnt_q    <= rcnt_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      wstate_q  <= wstate_d;
      wcnt_q    <= wcnt_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clk_core) begin
    if (gnt_r && rd_ok) ram_rd_q <= mem[rd_idx];
    if (gnt_w && wr_ok) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_hsv_core_dmem_responder.sv
// Directed bench for hsv_core_dmem_responder: one zero-wait instance and one 3-wait instance.
module tb_hsv_core_dmem_responder;
  localparam logic [31:0] BASE0 = 32'h0001_0000;
  localparam int unsigned SIZE0 = 4096;
  localparam logic [31:0] END0  = BASE0 + 32'(4 * SIZE0);

  logic clk_core = 1'b0;
  logic rst_core_n = 1'b0;
  always #5 clk_core = ~clk_core;

  int cyc = 0;
  always @(posedge clk_core) cyc <= cyc + 1;

  axil_if bus0();
  axil_if bus1();

  hsv_core_dmem_responder #(.ADDR_BASE(BASE0), .SIZE_WORDS(SIZE0), .WAIT_CYCLES(0)) u_dut0 (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .dmem(bus0));
  hsv_core_dmem_responder #(.ADDR_BASE(32'h0), .SIZE_WORDS(16), .WAIT_CYCLES(3)) u_dut1 (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .dmem(bus1));

  int checks = 0;
  int errors = 0;

  logic [31:0] t_rdata;
  logic [1:0]  t_rresp, t_bresp;
  int          t_ar_edge, t_r_edge, t_aw_edge, t_b_edge;
  bit          t_wrdy_bad, t_timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Optional read and optional write on bus0, run concurrently; AW may lag W by w_lead cycles.
  task automatic run(input bit do_rd, input logic [31:0] raddr, input bit do_wr,
                     input logic [31:0] waddr, input logic [31:0] wdat, input logic [3:0] strb,
                     input int w_lead);
    bit ar_d, r_d, aw_d, w_d, b_d;
    ar_d = !do_rd; r_d = !do_rd; aw_d = !do_wr; w_d = !do_wr; b_d = !do_wr;
    t_wrdy_bad = 0; t_timeout = 1; t_rdata = '0; t_rresp = '0; t_bresp = '0;
    t_ar_edge = 0; t_r_edge = 0; t_aw_edge = 0; t_b_edge = 0;
    @(negedge clk_core);
    for (int c = 0; c < 100; c++) begin
      bus0.araddr  = raddr;
      bus0.arvalid = !ar_d;
      bus0.awaddr  = waddr;
      bus0.awvalid = !aw_d && (c >= w_lead);
      bus0.wdata   = wdat;
      bus0.wstrb   = strb;
      bus0.wvalid  = !w_d;
      bus0.rready  = 1'b1;
      bus0.bready  = 1'b1;
      #1;
      if (do_wr && w_d && !aw_d && bus0.wready) t_wrdy_bad = 1;
      if (bus0.arvalid && bus0.arready) begin ar_d = 1; t_ar_edge = cyc + 1; end
      if (bus0.awvalid && bus0.awready) begin aw_d = 1; t_aw_edge = cyc + 1; end
      if (bus0.wvalid && bus0.wready) w_d = 1;
      if (!r_d && bus0.rvalid) begin
        r_d = 1; t_r_edge = cyc + 1; t_rdata = bus0.rdata; t_rresp = bus0.rresp;
      end
      if (!b_d && bus0.bvalid) begin
        b_d = 1; t_b_edge = cyc + 1; t_bresp = bus0.bresp;
      end
      @(posedge clk_core);
      @(negedge clk_core);
      if (r_d && b_d) begin t_timeout = 0; break; end
    end
    bus0.arvalid = 0; bus0.awvalid = 0; bus0.wvalid = 0; bus0.rready = 0; bus0.bready = 0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    run(0, '0, 1, addr, data, strb, 0);
  endtask

  task automatic rd(input logic [31:0] addr);
    run(1, addr, 0, '0, '0, '0, 0);
  endtask

  task automatic rd1(input logic [31:0] addr, output logic [31:0] data,
                     output logic [1:0] resp, output int lat);
    bit ar_d;
    int e_ar;
    ar_d = 0; e_ar = 0; lat = -1; data = '0; resp = '0;
    @(negedge clk_core);
    for (int c = 0; c < 60; c++) begin
      bus1.araddr = addr; bus1.arvalid = !ar_d; bus1.rready = 1'b1;
      #1;
      if (!ar_d && bus1.arready) begin
        ar_d = 1; e_ar = cyc + 1;
      end else if (ar_d && bus1.rvalid) begin
        lat = cyc + 1 - e_ar; data = bus1.rdata; resp = bus1.rresp;
      end
      @(posedge clk_core);
      @(negedge clk_core);
      if (lat >= 0) break;
    end
    bus1.arvalid = 0; bus1.rready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d1;
    logic [1:0]  r1;
    int          l1, ai, ri, stall_bad;
    bit          ar_hs;

    {bus0.araddr, bus0.arvalid, bus0.awaddr, bus0.awvalid, bus0.wdata, bus0.wstrb,
     bus0.wvalid, bus0.rready, bus0.bready} = '0;
    {bus1.araddr, bus1.arvalid, bus1.awaddr, bus1.awvalid, bus1.wdata, bus1.wstrb,
     bus1.wvalid, bus1.rready, bus1.bready} = '0;

    // reset values
    rst_core_n = 0;
    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    chk("rst_arready", bus0.arready, 0);
    chk("rst_awready", bus0.awready, 0);
    chk("rst_wready",  bus0.wready, 0);
    chk("rst_rvalid",  bus0.rvalid, 0);
    chk("rst_bvalid",  bus0.bvalid, 0);
    chk("rst_rdata",   bus0.rdata, 0);
    chk("rst_rresp",   bus0.rresp, 0);
    chk("rst_bresp",   bus0.bresp, 0);
    rst_core_n = 1;
    @(negedge clk_core); #1;
    chk("rel_arready", bus0.arready, 1);
    chk("rel_awready", bus0.awready, 1);
    chk("rel_wready",  bus0.wready, 1);

    // single write then read
    wr(BASE0 + 32'h10, 32'hDEAD_BEEF, 4'hF);
    chk("w1_timeout", t_timeout, 0);
    chk("w1_bresp", t_bresp, 2'b00);
    chk("w1_blat", t_b_edge - t_aw_edge, 2);
    rd(BASE0 + 32'h10);
    chk("r1_timeout", t_timeout, 0);
    chk("r1_rdata", t_rdata, 32'hDEAD_BEEF);
    chk("r1_rresp", t_rresp, 2'b00);
    chk("r1_rlat", t_r_edge - t_ar_edge, 3);

    // byte strobes, zero strobe, ignored low address bits
    wr(BASE0 + 32'h20, 32'h1122_3344, 4'hF);
    wr(BASE0 + 32'h20, 32'hAABB_CCDD, 4'b0101);
    rd(BASE0 + 32'h20);
    chk("strb_rdata", t_rdata, 32'h11BB_33DD);
    wr(BASE0 + 32'h20, 32'hFFFF_FFFF, 4'h0);
    chk("strb0_bresp", t_bresp, 2'b00);
    rd(BASE0 + 32'h23);
    chk("strb0_rdata", t_rdata, 32'h11BB_33DD);

    // out of range
    wr(BASE0, 32'h0BAD_F00D, 4'hF);
    rd(END0);
    chk("oor_rresp", t_rresp, 2'b10);
    chk("oor_rdata", t_rdata, 32'h0);
    wr(END0, 32'h1234_5678, 4'hF);
    chk("oor_bresp", t_bresp, 2'b10);
    rd(BASE0);
    chk("oor_word0", t_rdata, 32'h0BAD_F00D);
    chk("oor_word0_resp", t_rresp, 2'b00);
    rd(BASE0 - 32'h4);
    chk("below_rresp", t_rresp, 2'b10);
    rd(END0 - 32'h4);
    chk("last_rresp", t_rresp, 2'b00);

    // W presented 5 cycles before AW
    run(0, '0, 1, BASE0 + 32'h30, 32'hCAFE_F00D, 4'hF, 5);
    chk("skew_timeout", t_timeout, 0);
    chk("skew_wready_drop", t_wrdy_bad, 0);
    chk("skew_b_after_aw", t_b_edge - t_aw_edge, 2);
    rd(BASE0 + 32'h30);
    chk("skew_rdata", t_rdata, 32'hCAFE_F00D);

    // 8 reads back to back with rready toggling
    for (int i = 0; i < 8; i++) wr(BASE0 + 32'h100 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF);
    ai = 0; ri = 0; stall_bad = 0;
    @(negedge clk_core);
    for (int c = 0; c < 200; c++) begin
      bus0.arvalid = (ai < 8);
      bus0.araddr  = BASE0 + 32'h100 + 32'(4 * ai);
      bus0.rready  = c[0];
      #1;
      if (bus0.rvalid && !bus0.rready && bus0.arready) stall_bad++;
      ar_hs = bus0.arvalid && bus0.arready;
      if (bus0.rvalid && bus0.rready) begin
        chk($sformatf("pipe_rdata%0d", ri), bus0.rdata, 32'hA5A5_0000 + 32'(ri));
        ri++;
      end
      @(posedge clk_core);
      @(negedge clk_core);
      if (ar_hs) ai++;
      if (ri == 8) break;
    end
    bus0.arvalid = 0; bus0.rready = 0;
    chk("pipe_count", ri, 8);
    chk("pipe_stall_ar", stall_bad, 0);

    // read/write collision on the same word: write wins first, then read
    wr(BASE0 + 32'h40, 32'h0000_1111, 4'hF);
    run(1, BASE0 + 32'h40, 1, BASE0 + 32'h40, 32'h2222_2222, 4'hF, 0);
    chk("cont1_timeout", t_timeout, 0);
    chk("cont1_same_edge", t_ar_edge - t_aw_edge, 0);
    chk("cont1_rdata", t_rdata, 32'h2222_2222);
    chk("cont1_rlat", t_r_edge - t_ar_edge, 4);
    chk("cont1_blat", t_b_edge - t_aw_edge, 2);
    run(1, BASE0 + 32'h40, 1, BASE0 + 32'h40, 32'h3333_3333, 4'hF, 0);
    chk("cont2_rdata", t_rdata, 32'h2222_2222);
    chk("cont2_rlat", t_r_edge - t_ar_edge, 3);
    chk("cont2_blat", t_b_edge - t_aw_edge, 3);
    rd(BASE0 + 32'h40);
    chk("cont2_final", t_rdata, 32'h3333_3333);

    // WAIT_CYCLES=3 instance
    rd1(32'h8, d1, r1, l1);
    chk("w3_rlat", l1, 6);
    chk("w3_rresp", r1, 2'b00);
    rd1(32'h40, d1, r1, l1);
    chk("w3_oor_rlat", l1, 6);
    chk("w3_oor_rresp", r1, 2'b10);
    chk("w3_oor_rdata", d1, 32'h0);

    // reset while a write response is pending
    @(negedge clk_core);
    bus0.awaddr = BASE0 + 32'h50; bus0.awvalid = 1;
    bus0.wdata = 32'h5555_AAAA; bus0.wstrb = 4'hF; bus0.wvalid = 1; bus0.bready = 0;
    @(posedge clk_core);
    @(negedge clk_core);
    bus0.awvalid = 0; bus0.wvalid = 0;
    for (int c = 0; c < 20 && !bus0.bvalid; c++) @(negedge clk_core);
    chk("mid_bvalid_held", bus0.bvalid, 1);
    #2 rst_core_n = 0;
    #1;
    chk("mid_rst_bvalid", bus0.bvalid, 0);
    chk("mid_rst_awready", bus0.awready, 0);
    chk("mid_rst_arready", bus0.arready, 0);
    @(negedge clk_core);
    rst_core_n = 1;
    @(negedge clk_core); #1;
    chk("mid_rel_arready", bus0.arready, 1);
    chk("mid_rel_awready", bus0.awready, 1);
    chk("mid_rel_wready",  bus0.wready, 1);
    chk("mid_rel_bvalid",  bus0.bvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
